// File: rtl/ram_port_arbiter.sv
// Shares one single-port data RAM between the CPU MEM stage and VGA scan-out reads.
// Define ARB_STARVE_GUARD_EN to add the VGA starvation guard (forced VGA_HOLD bursts).
module ram_port_arbiter #(
  parameter int ADDR_W     = 5,
  parameter int STARVE_MAX = 8,
  parameter int VGA_BURST  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [31:0]       cpu_rdata,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic              vga_rvalid,
  output logic [31:0]       vga_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_we,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic {
    ARB      = 1'b0,
    VGA_HOLD = 1'b1
  } state_t;

  state_t state;
  logic   cpu_rd_q;
  logic   vga_rd_q;

  // Grants depend only on the current requests and the current state.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    cpu_gnt = 1'b0;
    vga_gnt = 1'b0;
    if (state == VGA_HOLD) begin
      vga_gnt = vga_req;
    end else begin
      cpu_gnt = cpu_req;
      vga_gnt = vga_req & ~cpu_req;
    end
  end

`ifdef ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int BW = $clog2(VGA_BURST + 1);

  state_t        state_nxt;
  logic [SW-1:0] starve_cnt;
  logic [SW-1:0] starve_nxt;
  logic [BW-1:0] burst_cnt;
  logic [BW-1:0] burst_nxt;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state      <= ARB;
      starve_cnt <= '0;
      burst_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      burst_cnt  <= burst_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    starve_nxt = '0;
    burst_nxt  = burst_cnt;

    if (vga_req && !vga_gnt) begin
      starve_nxt = (starve_cnt == SW'(STARVE_MAX)) ? starve_cnt : starve_cnt + SW'(1);
    end

    // The hold is entered on the edge that closes the STARVE_MAX-th denied cycle,
    // and left on the edge that closes the VGA_BURST-th held grant.
    case (state)
      ARB: begin
        if (vga_req && starve_nxt == SW'(STARVE_MAX)) begin
          state_nxt = VGA_HOLD;
          burst_nxt = '0;
        end
      end
      VGA_HOLD: begin
        if (vga_gnt) begin
          burst_nxt = burst_cnt + BW'(1);
        end
        if (!vga_req || burst_nxt == BW'(VGA_BURST)) begin
          state_nxt = ARB;
        end
      end
      default: state_nxt = ARB;
    endcase
  end
`else
  // Strict CPU priority: the arbiter never leaves ARB.
  assign state = ARB;

  logic unused_cfg;
  assign unused_cfg = ^{STARVE_MAX[0], VGA_BURST[0]};
`endif

  // Shared RAM command from whichever port owns this cycle.
  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    if (cpu_gnt) begin
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
      ram_we    = cpu_we;
    end else if (vga_gnt) begin
      ram_addr  = vga_addr;
    end
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;

  // Read-return pipeline runs independently of the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rd_q <= 1'b0;
      vga_rd_q <= 1'b0;
    end else begin
      cpu_rd_q <= cpu_gnt & ~cpu_we;
      vga_rd_q <= vga_gnt;
    end
  end

  // Masking with rst also drops a return that would land in a reset cycle.
  assign cpu_rvalid = cpu_rd_q & ~rst;
  assign vga_rvalid = vga_rd_q & ~rst;
  assign cpu_rdata  = cpu_rvalid ? ram_rdata : 32'h0;
  assign vga_rdata  = vga_rvalid ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural 1-cycle-latency RAM.
// Guard-dependent expectations follow ARB_STARVE_GUARD_EN.
module tb_ram_port_arbiter;

`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [4:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_gnt, cpu_stall, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        vga_req;
  logic [4:0]  vga_addr;
  logic        vga_gnt, vga_rvalid;
  logic [31:0] vga_rdata;
  logic [4:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_we;
  logic [31:0] ram_rdata;

  logic [31:0] mem [32];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ram_port_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
    .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
  );

  // Single-port RAM: data appears one cycle after the address.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    vga_req = 1'b0; vga_addr = '0;
  endtask

  initial begin
    bit ev;
    bit prev_cpu;
    bit prev_vga;
    int n;

    for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 | i;
    mem[3] = 32'h1234_5678;
    mem[9] = 32'hCAFE_0009;
    ram_rdata = '0;

    // Reset, then all outputs quiet with requests low.
    rst = 1'b1;
    idle();
    repeat (3) tick();
    rst = 1'b0;
    tick();
    #1;
    check("rst_cpu_gnt", cpu_gnt, 0);
    check("rst_vga_gnt", vga_gnt, 0);
    check("rst_cpu_stall", cpu_stall, 0);
    check("rst_cpu_rvalid", cpu_rvalid, 0);
    check("rst_vga_rvalid", vga_rvalid, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_vga_rdata", vga_rdata, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    check("rst_ram_we", ram_we, 0);

    // CPU read of address 3.
    tick();
    cpu_req = 1'b1; cpu_addr = 5'd3; #1;
    check("rd3_cpu_gnt", cpu_gnt, 1);
    check("rd3_cpu_stall", cpu_stall, 0);
    check("rd3_ram_addr", ram_addr, 3);
    check("rd3_ram_we", ram_we, 0);
    tick();
    idle(); #1;
    check("rd3_rvalid", cpu_rvalid, 1);
    check("rd3_rdata", cpu_rdata, 32'h1234_5678);
    check("rd3_vga_rvalid", vga_rvalid, 0);
    tick();
    #1;
    check("rd3_rvalid_drop", cpu_rvalid, 0);
    check("rd3_rdata_zero", cpu_rdata, 0);

    // Simultaneous requests with no starvation history: CPU wins.
    tick();
    cpu_req = 1'b1; cpu_addr = 5'd5; vga_req = 1'b1; vga_addr = 5'd9; #1;
    check("both_cpu_gnt", cpu_gnt, 1);
    check("both_vga_gnt", vga_gnt, 0);
    check("both_stall", cpu_stall, 0);
    check("both_ram_addr", ram_addr, 5);
    tick();
    idle(); #1;
    check("both_vga_rvalid", vga_rvalid, 0);
    check("both_vga_rdata", vga_rdata, 0);
    check("both_cpu_rdata", cpu_rdata, 32'h1000_0005);

    // VGA alone.
    tick();
    vga_req = 1'b1; vga_addr = 5'd9; #1;
    check("vga_gnt", vga_gnt, 1);
    check("vga_ram_addr", ram_addr, 9);
    check("vga_ram_we", ram_we, 0);
    check("vga_cpu_gnt", cpu_gnt, 0);
    tick();
    idle(); #1;
    check("vga_rvalid", vga_rvalid, 1);
    check("vga_rdata", vga_rdata, 32'hCAFE_0009);

    // CPU write, then reset during a VGA read grant.
    tick();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'd7; cpu_wdata = 32'hDEAD_BEEF; #1;
    check("wr_cpu_gnt", cpu_gnt, 1);
    check("wr_ram_we", ram_we, 1);
    check("wr_ram_addr", ram_addr, 7);
    check("wr_ram_wdata", ram_wdata, 32'hDEAD_BEEF);
    tick();
    idle();
    vga_req = 1'b1; vga_addr = 5'd7; rst = 1'b1; #1;
    check("wr_we_once", ram_we, 0);
    check("wr_no_rvalid", cpu_rvalid, 0);
    check("rstg_vga_gnt", vga_gnt, 1);
    tick();
    rst = 1'b0; idle(); #1;
    check("rstg_vga_rvalid", vga_rvalid, 0);
    check("rstg_vga_rdata", vga_rdata, 0);
    check("rstg_arb_cpu", cpu_gnt, 0);
    tick();
    vga_req = 1'b1; vga_addr = 5'd7; #1;
    check("rb_vga_gnt", vga_gnt, 1);
    tick();
    idle(); #1;
    check("rb_vga_rdata", vga_rdata, 32'hDEAD_BEEF);
    tick();

    // Both requests held: strict priority, or an 8/4/8 pattern with the guard.
    n = GUARD ? 20 : 30;
    prev_cpu = 1'b0;
    prev_vga = 1'b0;
    for (int i = 0; i < n; i++) begin
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd1; vga_req = 1'b1; vga_addr = 5'd2; #1;
      ev = GUARD && (i >= 8) && (i <= 11);
      check($sformatf("hold%0d_cpu_gnt", i), cpu_gnt, !ev);
      check($sformatf("hold%0d_vga_gnt", i), vga_gnt, ev);
      check($sformatf("hold%0d_stall", i), cpu_stall, ev);
      check($sformatf("hold%0d_ram_addr", i), ram_addr, ev ? 2 : 1);
      check($sformatf("hold%0d_cpu_rvalid", i), cpu_rvalid, prev_cpu);
      check($sformatf("hold%0d_vga_rvalid", i), vga_rvalid, prev_vga);
      check($sformatf("hold%0d_vga_rdata", i), vga_rdata, prev_vga ? 32'h1000_0002 : 32'h0);
      prev_cpu = !ev;
      prev_vga = ev;
      tick();
    end
    idle(); #1;
    check("hold_end_vga_rvalid", vga_rvalid, prev_vga);
    check("hold_end_cpu_rdata", cpu_rdata, 32'h1000_0001);
    tick();
    tick();

`ifdef ARB_STARVE_GUARD_EN
    // VGA request withdrawn after two held grants: back to ARB on the next cycle.
    for (int i = 0; i < 12; i++) begin
      cpu_req = 1'b1; cpu_addr = 5'd4; vga_req = (i < 10); vga_addr = 5'd6; #1;
      if (i < 8) begin
        check($sformatf("drop%0d_cpu_gnt", i), cpu_gnt, 1);
      end else if (i < 10) begin
        check($sformatf("drop%0d_vga_gnt", i), vga_gnt, 1);
        check($sformatf("drop%0d_stall", i), cpu_stall, 1);
      end else if (i == 10) begin
        check("drop10_cpu_gnt", cpu_gnt, 0);
        check("drop10_vga_gnt", vga_gnt, 0);
        check("drop10_stall", cpu_stall, 1);
        check("drop10_vga_rvalid", vga_rvalid, 1);
      end else begin
        check("drop11_cpu_gnt", cpu_gnt, 1);
        check("drop11_stall", cpu_stall, 0);
      end
      tick();
    end
    idle();
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
